// File: rtl/match_logger_if.sv
// Detector-side and host-side signals of match_logger bundled as one interface.
// The host (master) drives ans/clr/rd_en; the logger (slave) drives the rest.
interface match_logger_if #(
    parameter int CNT_W = 8,
    parameter int DUR_W = 8
) ();
    logic             ans;
    logic             clr;
    logic             rd_en;
    logic [DUR_W-1:0] rd_data;
    logic             empty;
    logic             full;
    logic             ovf;
    logic [CNT_W-1:0] match_cnt;
    logic             rise;

    modport master (
        output ans, clr, rd_en,
        input  rd_data, empty, full, ovf, match_cnt, rise
    );

    modport slave (
        input  ans, clr, rd_en,
        output rd_data, empty, full, ovf, match_cnt, rise
    );
endinterface

// File: rtl/match_logger.sv
// Counts rising edges of ans, measures each run length and queues it in a show-ahead FIFO.
// Define MATCH_LOGGER_SAT_EN to make match_cnt and run_len saturate instead of wrap.
module match_logger #(
    parameter int CNT_W = 8,
    parameter int DUR_W = 8,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    match_logger_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t           state;
    logic [DUR_W-1:0] run_len;
    logic [CNT_W-1:0] match_cnt;
    logic             rise;
    logic             ovf;
    logic [DUR_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      level;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             accept;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
`ifdef MATCH_LOGGER_SAT_EN
        return (&v) ? v : v + CNT_W'(1);
`else
        return v + CNT_W'(1);
`endif
    endfunction

    function automatic logic [DUR_W-1:0] dur_inc(input logic [DUR_W-1:0] v);
`ifdef MATCH_LOGGER_SAT_EN
        return (&v) ? v : v + DUR_W'(1);
`else
        return v + DUR_W'(1);
`endif
    endfunction

    // Pointers carry one extra wrap bit, so occupancy is a plain subtraction.
    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = level[AW];

    always_comb begin
        push   = 1'b0;
        pop    = 1'b0;
        accept = 1'b0;
        if (!bus.clr) begin
            push   = (state == RUN) && !bus.ans;
            pop    = bus.rd_en && !empty;
            accept = push && (!full || pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= run_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run_len   <= '0;
            match_cnt <= '0;
            rise      <= 1'b0;
            ovf       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else if (bus.clr) begin
            // A run still high at clear must not be counted or pushed when it ends.
            state     <= bus.ans ? WAIT_LOW : IDLE;
            run_len   <= '0;
            match_cnt <= '0;
            rise      <= 1'b0;
            ovf       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            rise <= 1'b0;
            if (pop) begin
                rd_ptr <= rd_ptr + (AW + 1)'(1);
            end
            if (accept) begin
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end else if (push) begin
                ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.ans) begin
                        state     <= RUN;
                        run_len   <= DUR_W'(1);
                        match_cnt <= cnt_inc(match_cnt);
                        rise      <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.ans) begin
                        run_len <= dur_inc(run_len);
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_LOW: begin
                    if (!bus.ans) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.ovf       = ovf;
    assign bus.match_cnt = match_cnt;
    assign bus.rise      = rise;
endmodule
